// File: rtl/data_mem_access.sv
// Load/store unit between the execute stage and a simple request/ack data bus.
// Accepts one access from IDLE, holds the bus request until ack or timeout,
// then spends one DONE cycle before returning to IDLE.
module data_mem_access #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] ALUOut,
    input  logic [31:0] rs2,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        MisalignErr,
    output logic        BusErr,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    // Wait counter wide enough to hold TIMEOUT_CYCLES-1.
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] rdata_q, rdata_d;
    logic        merr_q, merr_d;
    logic        berr_q, berr_d;

    logic        access, is_store, illegal, misaligned, start, reject;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_be;
    logic [7:0]  rd_byte [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    // Classify the incoming access; a simultaneous read+write is a store.
    always_comb begin
        access     = MemRead | MemWrite;
        is_store   = MemWrite;
        illegal    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) ||
                     (is_store && funct3[2]);
        misaligned = ((funct3[1:0] == 2'b01) && ALUOut[0]) ||
                     ((funct3[1:0] == 2'b10) && (ALUOut[1:0] != 2'b00));
        start      = access && !illegal && !misaligned;
        reject     = access && (illegal || misaligned);
    end

    // Replicate store data across lanes and derive the byte enables.
    always_comb begin
        lane_wdata = rs2;
        lane_be    = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                lane_wdata = {4{rs2[7:0]}};
                lane_be    = 4'b0001 << ALUOut[1:0];
            end
            2'b01: begin
                lane_wdata = {2{rs2[15:0]}};
                lane_be    = ALUOut[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                lane_wdata = rs2;
                lane_be    = 4'b1111;
            end
        endcase
    end

    // Split the returned word into byte lanes for the load extractor.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rd_lane
            assign rd_byte[gi] = bus_rdata[8*gi +: 8];
        end
    endgenerate

    // Pick the addressed byte/half from the bus word and extend it.
    always_comb begin
        byte_sel = rd_byte[off_q];
        half_sel = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (size_q)
            2'b00:   load_ext = uns_q ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_ext = uns_q ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_ext = bus_rdata;
        endcase
    end

    // Next-state, datapath next values and combinational handshake outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        off_d   = off_q;
        rdata_d = rdata_q;
        merr_d  = 1'b0;
        berr_d  = 1'b0;
        Stall   = 1'b0;
        bus_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    Stall   = 1'b1;
                    state_d = REQ;
                    cnt_d   = '0;
                    addr_d  = {ALUOut[31:2], 2'b00};
                    wdata_d = is_store ? lane_wdata : 32'd0;
                    be_d    = lane_be;
                    we_d    = is_store;
                    size_d  = funct3[1:0];
                    uns_d   = funct3[2];
                    off_d   = ALUOut[1:0];
                end else if (reject) begin
                    merr_d = 1'b1;
                    if (!is_store) begin
                        rdata_d = 32'd0;
                    end
                end
            end
            REQ: begin
                Stall   = 1'b1;
                bus_req = 1'b1;
                if (bus_ack) begin
                    // Ack wins even on the final counted cycle.
                    if (!we_q) begin
                        rdata_d = load_ext;
                    end
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    berr_d = 1'b1;
                    if (!we_q) begin
                        rdata_d = 32'd0;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched access attributes, wait counter, load result and error pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            off_q   <= 2'd0;
            rdata_q <= 32'd0;
            merr_q  <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
            rdata_q <= rdata_d;
            merr_q  <= merr_d;
            berr_q  <= berr_d;
        end
    end

    assign bus_we      = bus_req & we_q;
    assign bus_addr    = addr_q;
    assign bus_wdata   = wdata_q;
    assign bus_be      = be_q;
    assign ReadData    = rdata_q;
    assign MisalignErr = merr_q;
    assign BusErr      = berr_q;

endmodule

// File: tb/tb_data_mem_access.sv
// Directed bench for data_mem_access: table of accesses with hand-computed
// results, plus a reset-during-request scenario.
module tb_data_mem_access;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [2:0]  funct3;
    logic [31:0] ALUOut, rs2;
    logic [31:0] ReadData;
    logic        Stall, MisalignErr, BusErr;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    always #5 clk = ~clk;

    data_mem_access #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .funct3     (funct3),
        .ALUOut     (ALUOut),
        .rs2        (rs2),
        .ReadData   (ReadData),
        .Stall      (Stall),
        .MisalignErr(MisalignErr),
        .BusErr     (BusErr),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_be     (bus_be),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack)
    );

    int cmp_cnt = 0;
    int mis_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cmp_cnt++;
        if (got !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        int          ack_at;   // REQ cycle (1-based) carrying bus_ack, 0 = never
        logic [31:0] rdata;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_we;
        int          e_req;
        logic [31:0] e_rd;
        int          e_merr;
        int          e_berr;
    } vec_t;

    vec_t vecs[14];

    int          o_req, o_stall, o_merr, o_berr, o_unstable;
    logic [31:0] o_addr, o_wdata;
    logic [3:0]  o_be;
    logic        o_we;

    // Issue one access at posedge+1, run a fixed 24-cycle window, observe at negedges.
    task automatic run_access(input vec_t v);
        MemRead  = v.rd;
        MemWrite = v.wr;
        funct3   = v.f3;
        ALUOut   = v.addr;
        rs2      = v.wd;
        o_req = 0; o_stall = 0; o_merr = 0; o_berr = 0; o_unstable = 0;
        o_addr = 32'd0; o_wdata = 32'd0; o_be = 4'd0; o_we = 1'b0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (Stall) o_stall++;
            if (MisalignErr) o_merr++;
            if (BusErr) o_berr++;
            if (bus_req) begin
                o_req++;
                if (o_req == 1) begin
                    o_addr  = bus_addr;
                    o_wdata = bus_wdata;
                    o_be    = bus_be;
                    o_we    = bus_we;
                end else if (bus_addr !== o_addr || bus_wdata !== o_wdata ||
                             bus_be !== o_be || bus_we !== o_we) begin
                    o_unstable++;
                end
                bus_ack   = (o_req == v.ack_at);
                bus_rdata = v.rdata;
            end else begin
                bus_ack = 1'b0;
            end
            @(posedge clk);
            #1;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            bus_ack  = 1'b0;
        end
    endtask

    task automatic check_vec(input int idx, input vec_t v);
        int e_stall;
        e_stall = (v.e_req > 0) ? v.e_req + 1 : 0;
        $display("access %0d: addr=0x%08h req_cycles=%0d stall_cycles=%0d ReadData=0x%08h",
                 idx, v.addr, o_req, o_stall, ReadData);
        check_val($sformatf("v%0d_req_cycles", idx), 32'(o_req), 32'(v.e_req));
        check_val($sformatf("v%0d_stall_cycles", idx), 32'(o_stall), 32'(e_stall));
        check_val($sformatf("v%0d_readdata", idx), ReadData, v.e_rd);
        check_val($sformatf("v%0d_misalign_pulses", idx), 32'(o_merr), 32'(v.e_merr));
        check_val($sformatf("v%0d_buserr_pulses", idx), 32'(o_berr), 32'(v.e_berr));
        if (v.e_req > 0) begin
            check_val($sformatf("v%0d_bus_addr", idx), o_addr, v.e_addr);
            check_val($sformatf("v%0d_bus_we", idx), 32'(o_we), 32'(v.e_we));
            check_val($sformatf("v%0d_unstable", idx), 32'(o_unstable), 32'd0);
            if (v.e_we) begin
                check_val($sformatf("v%0d_bus_be", idx), 32'(o_be), 32'(v.e_be));
                check_val($sformatf("v%0d_bus_wdata", idx), o_wdata, v.e_wdata);
            end
        end
    endtask

    initial begin
        //          rd    wr    f3      addr          wd            ack rdata         e_addr        e_be     e_wdata       we    req e_rd          merr berr
        vecs[0]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        3,  32'h80FF_1234, 32'h0000_0100, 4'b1000, 32'h0,        1'b0, 3,  32'hFFFF_FF80, 0, 0}; // LB
        vecs[1]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 1,  32'hFFFF_FFFF, 32'h0000_0200, 4'b1100, 32'hBEEF_BEEF, 1'b1, 1,  32'hFFFF_FF80, 0, 0}; // SH
        vecs[2]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h1234_5678, 2,  32'h0,        32'h0000_0100, 4'b0010, 32'h7878_7878, 1'b1, 2,  32'hFFFF_FF80, 0, 0}; // SB
        vecs[3]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0006, 32'h0,        1,  32'h8001_7FFF, 32'h0000_0004, 4'b1100, 32'h0,        1'b0, 1,  32'hFFFF_8001, 0, 0}; // LH
        vecs[4]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0001, 32'h0,        2,  32'h0000_F000, 32'h0000_0000, 4'b0010, 32'h0,        1'b0, 2,  32'h0000_00F0, 0, 0}; // LBU
        vecs[5]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0,        1,  32'hDEAD_BEEF, 32'h0000_0010, 4'b1111, 32'h0,        1'b0, 1,  32'hDEAD_BEEF, 0, 0}; // LW
        vecs[6]  = '{1'b0, 1'b1, 3'b101, 32'h0000_0000, 32'h0000_FFFF, 0,  32'h0,        32'h0,         4'b0000, 32'h0,        1'b0, 0,  32'hDEAD_BEEF, 1, 0}; // illegal store
        vecs[7]  = '{1'b1, 1'b0, 3'b011, 32'h0000_0008, 32'h0,        0,  32'h0,        32'h0,         4'b0000, 32'h0,        1'b0, 0,  32'h0000_0000, 1, 0}; // illegal load
        vecs[8]  = '{1'b1, 1'b1, 3'b010, 32'h0000_0030, 32'h0BAD_F00D, 1,  32'h1111_1111, 32'h0000_0030, 4'b1111, 32'h0BAD_F00D, 1'b1, 1,  32'h0000_0000, 0, 0}; // read+write = store
        vecs[9]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0014, 32'h0,        16, 32'h1357_9BDF, 32'h0000_0014, 4'b1111, 32'h0,        1'b0, 16, 32'h1357_9BDF, 0, 0}; // ack on last cycle
        vecs[10] = '{1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0,        0,  32'h0,        32'h0,         4'b0000, 32'h0,        1'b0, 0,  32'h0000_0000, 1, 0}; // misaligned LW
        vecs[11] = '{1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'h0,        1,  32'h2468_ACE0, 32'h0000_0020, 4'b1111, 32'h0,        1'b0, 1,  32'h2468_ACE0, 0, 0}; // LW
        vecs[12] = '{1'b1, 1'b0, 3'b010, 32'h0000_0084, 32'h0,        2,  32'h5A5A_0001, 32'h0000_0084, 4'b1111, 32'h0,        1'b0, 2,  32'h5A5A_0001, 0, 0}; // LW after reset
        vecs[13] = '{1'b1, 1'b0, 3'b101, 32'h0000_0000, 32'h0,        0,  32'hFFFF_FFFF, 32'h0000_0000, 4'b0011, 32'h0,        1'b0, 16, 32'h0000_0000, 0, 1}; // LHU timeout

        reset = 1'b0;
        MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'b000;
        ALUOut = 32'd0; rs2 = 32'd0; bus_rdata = 32'd0; bus_ack = 1'b0;

        #2;
        check_val("rst_readdata", ReadData, 32'd0);
        check_val("rst_stall", 32'(Stall), 32'd0);
        check_val("rst_bus_req", 32'(bus_req), 32'd0);
        check_val("rst_bus_addr", bus_addr, 32'd0);
        check_val("rst_bus_be", 32'(bus_be), 32'd0);
        check_val("rst_errs", 32'({MisalignErr, BusErr}), 32'd0);

        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;

        for (int i = 0; i <= 11; i++) begin
            run_access(vecs[i]);
            check_vec(i, vecs[i]);
        end

        // Reset asserted two cycles into REQ of a word load.
        MemRead = 1'b1; funct3 = 3'b010; ALUOut = 32'h0000_0080;
        @(posedge clk);
        #1 MemRead = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_val("rstreq_pre_bus_req", 32'(bus_req), 32'd1);
        check_val("rstreq_pre_readdata", ReadData, 32'h2468_ACE0);
        #2 reset = 1'b0;
        #1;
        check_val("rstreq_bus_req", 32'(bus_req), 32'd0);
        check_val("rstreq_stall", 32'(Stall), 32'd0);
        check_val("rstreq_bus_addr", bus_addr, 32'd0);
        check_val("rstreq_readdata", ReadData, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        bus_ack = 1'b1;
        bus_rdata = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 bus_ack = 1'b0;
        @(negedge clk);
        $display("reset-in-REQ: bus_req=%0b Stall=%0b ReadData=0x%08h after late ack", bus_req, Stall, ReadData);
        check_val("late_ack_bus_req", 32'(bus_req), 32'd0);
        check_val("late_ack_stall", 32'(Stall), 32'd0);
        check_val("late_ack_readdata", ReadData, 32'd0);
        @(posedge clk);
        #1;

        for (int i = 12; i <= 13; i++) begin
            run_access(vecs[i]);
            check_vec(i, vecs[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
        $finish;
    end

endmodule

// File: doc/data_mem_access.md
DATA_MEM_ACCESS -- requirements
Module: data_mem_access

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum cycles spent waiting for bus_ack before an access is aborted.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 MemRead  input  1  the current instruction is a load.
REQ-005 MemWrite  input  1  the current instruction is a store.
REQ-006 funct3  input  3  access size: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-007 ALUOut  input  32  effective byte address.
REQ-008 rs2  input  32  store data.
REQ-009 ReadData  output  32  extended load result, consumed by the writeback mux.
REQ-010 Stall  output  1  freezes PC and pipeline inputs while an access is pending.
REQ-011 MisalignErr  output  1  one-cycle pulse for a misaligned or illegal access.
REQ-012 BusErr  output  1  one-cycle pulse when an access times out.
REQ-013 bus_req, bus_we  output  1 each  bus request and write enable.
REQ-014 bus_addr  output  32  word-aligned address, {ALUOut[31:2],2'b00}.
REQ-015 bus_wdata  output  32  lane-replicated store data.
REQ-016 bus_be  output  4  byte enables.
REQ-017 bus_rdata  input  32  bus read data, valid when bus_ack=1.
REQ-018 bus_ack  input  1  one-cycle bus completion.

Function
REQ-019 The controller SHALL be an FSM with states IDLE, REQ, DONE.
REQ-020 IDLE with (MemRead|MemWrite)=1 and a legal, aligned access SHALL:
- latch address, write data, byte enables, size and sign;
- move to REQ;
- drive Stall=1 combinationally in the same cycle.
REQ-021 In REQ the block SHALL hold bus_req=1 and all bus outputs stable until bus_ack=1, then capture the extended bus_rdata and move to DONE.
REQ-022 DONE SHALL drive Stall=0 for exactly one cycle and then return to IDLE; new requests are not accepted in DONE.
REQ-023 Stall SHALL be 1 in REQ, and in IDLE when a legal access starts; 0 otherwise.
REQ-024 When MemRead and MemWrite are both 1, the access SHALL be treated as a store.
REQ-025 Store lanes SHALL be generated as follows:
- SB: rs2[7:0] replicated to all four bytes, bus_be = 4'b0001 << ALUOut[1:0].
- SH: rs2[15:0] replicated to both halves, bus_be = 0011 when ALUOut[1]=0, else 1100.
- SW: bus_be = 1111.
REQ-026 Load extraction SHALL select the byte or half indicated by ALUOut[1:0]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes the full word.
REQ-027 ReadData SHALL hold the last completed load value until the next load completes; stores SHALL NOT change it.
REQ-028 A misaligned access SHALL NOT issue a bus cycle. Misaligned means: half access with ALUOut[0]=1, or word access with ALUOut[1:0]!=0.
REQ-029 An illegal access SHALL NOT issue a bus cycle. Illegal means: funct3 of 011, 110 or 111, or a store with funct3 of 100 or 101.
REQ-030 For a misaligned or illegal access the block SHALL pulse MisalignErr for one cycle, keep Stall=0, and set ReadData=0 for loads.
REQ-031 A wait counter SHALL clear on entry to REQ and increment each REQ cycle without bus_ack. When it reaches TIMEOUT_CYCLES-1 without bus_ack:
- pulse BusErr;
- deassert bus_req;
- set ReadData=0 for loads (stores are dropped);
- go to DONE.
REQ-032 bus_ack arriving on the same cycle as the timeout SHALL take priority, and BusErr SHALL NOT pulse.
REQ-033 bus_ack received in IDLE or DONE SHALL be ignored.
REQ-034 bus_req SHALL be 0 outside REQ.
REQ-035 bus_we SHALL equal the latched store flag while bus_req=1.

Reset
REQ-036 While reset=0, the following SHALL be held, asynchronously: state IDLE; bus_req=0; bus_we=0; bus_addr=0; bus_wdata=0; bus_be=0; ReadData=0; Stall=0; MisalignErr=0; BusErr=0; counter=0.
REQ-037 Reset asserted during REQ SHALL drop bus_req immediately and discard the access; no ack is expected afterwards.

Verification
REQ-038 LB at address 0x103, bus_rdata=0x80FF_1234 with ack after 3 cycles -> bus_addr=0x100, Stall high for 4 cycles, ReadData=0xFFFF_FF80.
REQ-039 SH with rs2=0x0000_BEEF at address 0x202 -> bus_we=1, bus_be=1100, bus_wdata=0xBEEF_BEEF; ReadData is unchanged.
REQ-040 LW at address 0x101 -> MisalignErr pulses once, bus_req stays 0, Stall=0, ReadData=0.
REQ-041 LHU at address 0x0, no ack -> BusErr pulses after 16 REQ cycles, ReadData=0, FSM passes through DONE to IDLE.
REQ-042 reset driven low two cycles into REQ -> bus_req=0 immediately; after release, state is IDLE, a late bus_ack has no effect, and a following LW completes normally.
